// File: rtl/lc3b_victim_buffer_if.sv
// Bus bundle for lc3b_victim_buffer.
//   L1 eviction side : wb_write, wb_addr, wb_wdata -> wb_accept, wb_full
//   L1 lookup side   : lk_addr -> lk_hit, lk_rdata
//   Memory side      : mem_write, mem_addr, mem_wdata <- mem_resp
//   Status           : count, empty
// The slave modport is the buffer; the master modport is the L1/memory environment.
interface lc3b_victim_buffer_if #(
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 4,
  parameter int DEPTH       = 4
);
  localparam int LA = ADDR_WIDTH - OFFSET_BITS;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wb_write;
  logic [LA-1:0]         wb_addr;
  logic [LINE_WIDTH-1:0] wb_wdata;
  logic                  wb_full;
  logic                  wb_accept;
  logic [LA-1:0]         lk_addr;
  logic                  lk_hit;
  logic [LINE_WIDTH-1:0] lk_rdata;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  mem_resp;
  logic [CW-1:0]         count;
  logic                  empty;

  modport master (
    output wb_write, wb_addr, wb_wdata, lk_addr, mem_resp,
    input  wb_full, wb_accept, lk_hit, lk_rdata, mem_write, mem_addr, mem_wdata,
           count, empty
  );

  modport slave (
    input  wb_write, wb_addr, wb_wdata, lk_addr, mem_resp,
    output wb_full, wb_accept, lk_hit, lk_rdata, mem_write, mem_addr, mem_wdata,
           count, empty
  );
endinterface

// File: rtl/lc3b_victim_buffer.sv
// Write-back / victim buffer between L1 D-cache and memory.
// Evicted dirty lines are queued in a circular FIFO and drained in order through
// an IDLE/WRITE/GAP handshake. Re-evictions of a queued (non-head) line coalesce
// into the existing entry; L1 miss lookups see the youngest buffered copy.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : lc3b_victim_buffer_if.slave (eviction, lookup, memory, status)
module lc3b_victim_buffer #(
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 4,
  parameter int DEPTH       = 4
) (
  input  logic clk,
  input  logic reset_n,
  lc3b_victim_buffer_if.slave bus
);
  localparam int LA = ADDR_WIDTH - OFFSET_BITS;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [LA-1:0]         addr_q [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];

  logic                  full, pop, alloc, coal_hit;
  logic [PW-1:0]         coal_idx, lk_idx;
  logic                  lk_hit_c;
  logic [LINE_WIDTH-1:0] lk_data_c;

  assign full  = (count_q == CW'(DEPTH));
  assign pop   = (state_q == S_WRITE) && bus.mem_resp;
  assign alloc = bus.wb_write && !coal_hit && !full;

  // The head may be mid-drain, so it is never rewritten; only later entries
  // are coalesce targets. Allocation never creates a second non-head copy,
  // so at most one index can match here.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.wb_addr) && (PW'(i) != head_q)) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  // Walk from oldest to youngest so the youngest match is the one kept.
  always_comb begin
    lk_hit_c  = 1'b0;
    lk_data_c = '0;
    lk_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_q + PW'(k);
      if (valid_q[lk_idx] && (addr_q[lk_idx] == bus.lk_addr)) begin
        lk_hit_c  = 1'b1;
        lk_data_c = data_q[lk_idx];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (pop)   valid_d[head_q] = 1'b0;
    if (alloc) valid_d[tail_q] = 1'b1;
    head_d  = pop   ? head_q + PW'(1) : head_q;
    tail_d  = alloc ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(alloc) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_WRITE;
      S_WRITE: if (bus.mem_resp)  state_d = S_GAP;
      S_GAP:   state_d = (count_q != '0) ? S_WRITE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Line storage carries no reset; every read is qualified by valid or state.
  always_ff @(posedge clk) begin
    if (bus.wb_write && coal_hit) begin
      data_q[coal_idx] <= bus.wb_wdata;
    end else if (alloc) begin
      addr_q[tail_q] <= bus.wb_addr;
      data_q[tail_q] <= bus.wb_wdata;
    end
  end

  assign bus.wb_full   = full;
  assign bus.wb_accept = bus.wb_write && (coal_hit || !full);
  assign bus.lk_hit    = lk_hit_c;
  assign bus.lk_rdata  = lk_data_c;
  assign bus.mem_write = (state_q == S_WRITE);
  // Memory outputs are zeroed outside WRITE so reset forces them low.
  assign bus.mem_addr  = bus.mem_write ? {addr_q[head_q], {OFFSET_BITS{1'b0}}} : '0;
  assign bus.mem_wdata = bus.mem_write ? data_q[head_q] : '0;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
endmodule

// File: tb/tb_lc3b_victim_buffer.sv
module tb_lc3b_victim_buffer;
  localparam int LW = 128;
  localparam int AW = 16;
  localparam int OB = 4;
  localparam int DEPTH = 4;
  localparam int LA = AW - OB;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lc3b_victim_buffer_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(OB), .DEPTH(DEPTH)) bus ();

  lc3b_victim_buffer #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(OB), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: queue element 0 is the line currently at the head of the buffer.
  logic [LA-1:0] mq_addr[$];
  logic [LW-1:0] mq_data[$];
  bit last_pop;
  int streak;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    mq_addr.delete();
    mq_data.delete();
    last_pop = 1'b0;
    streak   = 0;
  endtask

  // One clock cycle: entered just after a falling edge, returns at the next one.
  task automatic cyc(input logic wr, input logic [LA-1:0] a, input logic [LW-1:0] d,
                     input logic [LA-1:0] lk, input logic resp);
    int n, ci;
    bit coal, eacc, ehit, mw;
    logic [LW-1:0] edata;
    bus.wb_write = wr;
    bus.wb_addr  = a;
    bus.wb_wdata = d;
    bus.lk_addr  = lk;
    bus.mem_resp = resp;
    #1;
    n = mq_addr.size();
    coal = 1'b0;
    ci = 0;
    for (int i = 1; i < n; i++) if (mq_addr[i] == a) begin coal = 1'b1; ci = i; end
    eacc = wr && (coal || n < DEPTH);
    ehit = 1'b0;
    edata = '0;
    for (int i = 0; i < n; i++) if (mq_addr[i] == lk) begin ehit = 1'b1; edata = mq_data[i]; end
    chk("count",     LW'(bus.count),     LW'(n));
    chk("empty",     LW'(bus.empty),     LW'(n == 0));
    chk("wb_full",   LW'(bus.wb_full),   LW'(n == DEPTH));
    chk("wb_accept", LW'(bus.wb_accept), LW'(eacc));
    chk("lk_hit",    LW'(bus.lk_hit),    LW'(ehit));
    chk("lk_rdata",  bus.lk_rdata,       edata);
    mw = bus.mem_write;
    if (n == 0) chk("mw_when_empty", LW'(mw), LW'(0));
    if (last_pop) chk("mw_gap", LW'(mw), LW'(0));
    if (mw && n > 0) begin
      chk("mem_addr",  LW'(bus.mem_addr), LW'({mq_addr[0], 4'h0}));
      chk("mem_wdata", bus.mem_wdata,     mq_data[0]);
    end
    streak = (n > 0 && !mw) ? streak + 1 : 0;
    if (n > 0) chk("mw_latency", LW'(streak <= 1), LW'(1));
    @(posedge clk);
    if (eacc) begin
      if (coal) mq_data[ci] = d;
      else begin mq_addr.push_back(a); mq_data.push_back(d); end
    end
    last_pop = resp && mw;
    if (last_pop) begin void'(mq_addr.pop_front()); void'(mq_data.pop_front()); end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wait_mw();
    for (int i = 0; i < 8 && bus.mem_write !== 1'b1; i++) idle();
    chk("mw_timeout", LW'(bus.mem_write), LW'(1));
  endtask

  task automatic drain_one();
    wait_mw();
    cyc(1'b0, '0, '0, '0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] d0, d1, da, d9;
    logic [LW-1:0] dl [4];
    logic [LA-1:0] na;
    reset_n = 1'b0;
    bus.wb_write = 1'b0; bus.wb_addr = '0; bus.wb_wdata = '0;
    bus.lk_addr = '0; bus.mem_resp = 1'b0;
    model_clear();
    #3;
    chk("rst_mem_write", LW'(bus.mem_write), LW'(0));
    chk("rst_mem_addr",  LW'(bus.mem_addr),  LW'(0));
    chk("rst_mem_wdata", bus.mem_wdata,      LW'(0));
    chk("rst_wb_full",   LW'(bus.wb_full),   LW'(0));
    chk("rst_empty",     LW'(bus.empty),     LW'(1));
    chk("rst_count",     LW'(bus.count),     LW'(0));
    chk("rst_lk_hit",    LW'(bus.lk_hit),    LW'(0));
    chk("rst_lk_rdata",  bus.lk_rdata,       LW'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    // Single line: 2-cycle latency, address formation, pop.
    d0 = rnd_line();
    cyc(1'b1, LA'('h0A5), d0, LA'('h0A5), 1'b0);
    cyc(1'b0, '0, '0, LA'('h0A5), 1'b0);
    chk("t1_mw",    LW'(bus.mem_write), LW'(1));
    chk("t1_addr",  LW'(bus.mem_addr),  LW'(16'h0A50));
    chk("t1_wdata", bus.mem_wdata,      d0);
    cyc(1'b0, '0, '0, '0, 1'b1);
    chk("t1_empty", LW'(bus.empty),     LW'(1));
    chk("t1_gap",   LW'(bus.mem_write), LW'(0));
    idle();

    // Fill with memory stalled, reject when full, coalesce into a non-head entry.
    for (int i = 0; i < 4; i++) begin
      dl[i] = rnd_line();
      cyc(1'b1, LA'(i + 1), dl[i], '0, 1'b0);
    end
    chk("t2_full", LW'(bus.wb_full), LW'(1));
    cyc(1'b1, LA'(5), rnd_line(), '0, 1'b0);
    d9 = rnd_line();
    cyc(1'b1, LA'(3), d9, LA'(3), 1'b0);
    chk("t2_count", LW'(bus.count), LW'(4));
    for (int i = 0; i < 4; i++) begin
      wait_mw();
      chk("t2_order_addr", LW'(bus.mem_addr), LW'({LA'(i + 1), 4'h0}));
      chk("t2_order_data", bus.mem_wdata, (i == 2) ? d9 : dl[i]);
      cyc(1'b0, '0, '0, '0, 1'b1);
    end
    idle();

    // Match on the head alone allocates; lookup returns the youngest copy.
    da = rnd_line();
    d1 = rnd_line();
    cyc(1'b1, LA'('h010), da, '0, 1'b0);
    wait_mw();
    cyc(1'b1, LA'('h010), d1, LA'('h010), 1'b0);
    chk("t3_count", LW'(bus.count), LW'(2));
    cyc(1'b0, '0, '0, LA'('h010), 1'b0);
    wait_mw();
    chk("t3_first", bus.mem_wdata, da);
    cyc(1'b0, '0, '0, '0, 1'b1);
    wait_mw();
    chk("t3_second", bus.mem_wdata, d1);
    cyc(1'b0, '0, '0, '0, 1'b1);
    idle();

    // No same-cycle bypass into lookup.
    cyc(1'b1, LA'('h020), rnd_line(), LA'('h020), 1'b0);
    cyc(1'b0, '0, '0, LA'('h020), 1'b0);
    drain_one();
    idle();

    // Full buffer: pop plus allocating write rejects, retry accepts; 3 rotations.
    for (int i = 0; i < 4; i++) cyc(1'b1, LA'('h100 + i), rnd_line(), '0, 1'b0);
    for (int r = 0; r < 3 * DEPTH; r++) begin
      na = LA'('h200 + r);
      d1 = rnd_line();
      wait_mw();
      cyc(1'b1, na, d1, '0, 1'b1);
      chk("t5_rej_count", LW'(bus.count), LW'(3));
      cyc(1'b1, na, d1, na, 1'b0);
      chk("t5_retry_count", LW'(bus.count), LW'(4));
    end
    for (int i = 0; i < 4; i++) drain_one();
    idle();

    // Reset during a memory write.
    cyc(1'b1, LA'('h033), rnd_line(), '0, 1'b0);
    cyc(1'b1, LA'('h034), rnd_line(), '0, 1'b0);
    wait_mw();
    bus.lk_addr = LA'('h033);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_mw_async", LW'(bus.mem_write), LW'(0));
    chk("t6_empty",    LW'(bus.empty),     LW'(1));
    chk("t6_lk_hit",   LW'(bus.lk_hit),    LW'(0));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, '0, 1'b1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), LA'($urandom_range(0, 7)), rnd_line(),
          LA'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 40 && mq_addr.size() > 0; i++) cyc(1'b0, '0, '0, '0, 1'b1);
    idle();
    chk("final_empty", LW'(bus.empty), LW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
